// File: rtl/display_pkg.sv
// Shared types, width helpers and timing defaults
// for the display mode multiplexer.
package display_pkg;

  typedef enum logic {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } disp_state_e;

  localparam int DEF_NUM_MODES    = 8;
  localparam int DEF_SEG_W        = 8;
  localparam int DEF_DIG_W        = 8;
  localparam int DEF_DEB_CYCLES   = 1000000;
  localparam int DEF_BLANK_CYCLES = 4;
  localparam int DEF_AUTO_CYCLES  = 100000000;

  function automatic int mode_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that must hold 0..n-1.
  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus level debouncer for one
// raw button, emitting a one-cycle pulse per press.
module btn_debounce
  import display_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic rise_o
);

  localparam int CW = cnt_w(DEB_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEB_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          level_d;
  logic          armed_q;
  logic          armed_d;
  logic          rise_q;
  logic          rise_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Pressing is only honoured once the synchronised
  // input has been seen low, so a held button at reset
  // needs a release before it can step.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    armed_d = armed_q | ~sync2_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CMAX) begin
        level_d = sync2_q;
        rise_d  = sync2_q & armed_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b0;
      armed_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      armed_q <= armed_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/display_mode_mux.sv
// Selects one of NUM_MODES display channels via buttons,
// idle auto-advance and channel enables, with blanking.
module display_mode_mux
  import display_pkg::*;
#(
  parameter int NUM_MODES    = DEF_NUM_MODES,
  parameter int SEG_W        = DEF_SEG_W,
  parameter int DIG_W        = DEF_DIG_W,
  parameter int DEB_CYCLES   = DEF_DEB_CYCLES,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
  parameter int AUTO_CYCLES  = DEF_AUTO_CYCLES
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         btn_left,
  input  logic                         btn_right,
  input  logic                         lock,
  input  logic                         auto_en,
  input  logic [NUM_MODES-1:0]         chan_en,
  input  logic [NUM_MODES*SEG_W-1:0]   chan_seg,
  input  logic [NUM_MODES*DIG_W-1:0]   chan_dig,
  output logic [mode_w(NUM_MODES)-1:0] mode,
  output logic [SEG_W-1:0]             seg,
  output logic [DIG_W-1:0]             dig,
  output logic                         mode_chg
);

  localparam int MODE_W = mode_w(NUM_MODES);
  localparam int IW     = cnt_w(AUTO_CYCLES);
  localparam int BW     = cnt_w(BLANK_CYCLES);
  localparam logic [IW-1:0] IMAX = IW'(AUTO_CYCLES - 1);
  localparam logic [BW-1:0] BMAX =
    BW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  logic              step_l;
  logic              step_r;

  disp_state_e       state_q;
  disp_state_e       state_d;
  logic [MODE_W-1:0] mode_q;
  logic [MODE_W-1:0] mode_d;
  logic [BW-1:0]     blank_q;
  logic [BW-1:0]     blank_d;
  logic [IW-1:0]     idle_q;
  logic [IW-1:0]     idle_d;
  logic              upd_q;
  logic              upd_d;
  logic              chg_q;
  logic              chg_d;
  logic [SEG_W-1:0]  seg_q;
  logic [SEG_W-1:0]  seg_d;
  logic [DIG_W-1:0]  dig_q;
  logic [DIG_W-1:0]  dig_d;

  logic              any_en;
  logic              show;
  logic              forced;
  logic              btn_ok;
  logic              auto_req;
  logic              accept;
  logic              go_right;
  logic              changed;
  logic [MODE_W-1:0] target;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb_left (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_i (btn_left),
    .rise_o(step_l)
  );

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb_right (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_i (btn_right),
    .rise_o(step_r)
  );

  // Nearest enabled channel in the given direction,
  // or cur itself when no other channel is enabled.
  function automatic logic [MODE_W-1:0] find_next(
    input logic [MODE_W-1:0]    cur,
    input logic                 right,
    input logic [NUM_MODES-1:0] en
  );
    logic [MODE_W-1:0] res;
    logic              hit;
    int                idx;
    res = cur;
    hit = 1'b0;
    for (int k = 1; k < NUM_MODES; k++) begin
      idx = right ? int'(cur) + k : int'(cur) - k;
      if (idx >= NUM_MODES) idx = idx - NUM_MODES;
      if (idx < 0) idx = idx + NUM_MODES;
      if (!hit && en[idx]) begin
        res = MODE_W'(idx);
        hit = 1'b1;
      end
    end
    return res;
  endfunction

  // Priority: skip off a disabled channel, then a single
  // button, then auto-advance.
  always_comb begin
    any_en   = |chan_en;
    show     = (state_q == SHOW);
    forced   = show & ~lock & any_en & ~chan_en[mode_q];
    btn_ok   = show & ~lock & (step_l ^ step_r);
    auto_req = show & auto_en & ~lock & (idle_q == IMAX);
    accept   = forced | btn_ok | auto_req;
    go_right = forced | ~btn_ok | step_r;
    target   = find_next(mode_q, go_right, chan_en);
    changed  = accept & (target != mode_q);
    mode_d   = changed ? target : mode_q;
    upd_d    = changed;
    chg_d    = upd_q;
  end

  always_comb begin
    state_d = state_q;
    blank_d = blank_q;
    unique case (state_q)
      SHOW: begin
        if (changed && BLANK_CYCLES > 0) begin
          state_d = BLANK;
          blank_d = '0;
        end
      end
      BLANK: begin
        if (blank_q == BMAX) begin
          state_d = SHOW;
          blank_d = '0;
        end else begin
          blank_d = blank_q + BW'(1);
        end
      end
    endcase
  end

  // Idle time is frozen while blanking.
  always_comb begin
    idle_d = idle_q;
    if (!auto_en || lock || accept) begin
      idle_d = '0;
    end else if (show) begin
      idle_d = idle_q + IW'(1);
    end
  end

  always_comb begin
    seg_d = '0;
    dig_d = '0;
    if (state_d == SHOW && any_en) begin
      seg_d = chan_seg[int'(mode_d)*SEG_W +: SEG_W];
      dig_d = chan_dig[int'(mode_d)*DIG_W +: DIG_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SHOW;
      mode_q  <= '0;
      blank_q <= '0;
      idle_q  <= '0;
      upd_q   <= 1'b0;
      chg_q   <= 1'b0;
      seg_q   <= '0;
      dig_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      blank_q <= blank_d;
      idle_q  <= idle_d;
      upd_q   <= upd_d;
      chg_q   <= chg_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
    end
  end

  assign mode     = mode_q;
  assign seg      = seg_q;
  assign dig      = dig_q;
  assign mode_chg = chg_q;

endmodule

// File: tb/tb_display_mode_mux.sv
// Randomised bench for display_mode_mux checked every
// cycle against a behavioural model, plus fixed scenarios.
module tb_display_mode_mux;

  localparam int N  = 8;
  localparam int DB = 4;
  localparam int BL = 2;
  localparam int AU = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          btn_left = 1'b0;
  logic          btn_right = 1'b0;
  logic          lock = 1'b0;
  logic          auto_en = 1'b0;
  logic [N-1:0]  chan_en = 8'hFF;
  logic [N*8-1:0] chan_seg = '0;
  logic [N*8-1:0] chan_dig = '0;
  logic [2:0]    mode;
  logic [7:0]    seg;
  logic [7:0]    dig;
  logic          mode_chg;

  int vecs = 0;
  int errs = 0;
  int chg_seen = 0;

  // Model: current mode, remaining blank cycles, idle count.
  int       m_mode = 0;
  int       m_blank_left = 0;
  int       m_idle = 0;
  bit       m_upd = 0;
  bit       m_chg = 0;
  bit [7:0] m_seg = 0;
  bit [7:0] m_dig = 0;
  // Per button (0 left, 1 right): sync pipe, accepted level,
  // streak of samples disagreeing with it, press armed.
  bit b_s1[2];
  bit b_s2[2];
  bit b_lvl[2];
  bit b_arm[2];
  bit b_rise[2];
  int b_run[2];

  always #5 clk = ~clk;

  display_mode_mux #(
    .NUM_MODES   (N),
    .SEG_W       (8),
    .DIG_W       (8),
    .DEB_CYCLES  (DB),
    .BLANK_CYCLES(BL),
    .AUTO_CYCLES (AU)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_left (btn_left),
    .btn_right(btn_right),
    .lock     (lock),
    .auto_en  (auto_en),
    .chan_en  (chan_en),
    .chan_seg (chan_seg),
    .chan_dig (chan_dig),
    .mode     (mode),
    .seg      (seg),
    .dig      (dig),
    .mode_chg (mode_chg)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_blank_left = 0; m_idle = 0;
    m_upd = 0; m_chg = 0; m_seg = 0; m_dig = 0;
    for (int b = 0; b < 2; b++) begin
      b_s1[b] = 1; b_s2[b] = 1; b_lvl[b] = 0;
      b_arm[b] = 0; b_rise[b] = 0; b_run[b] = 0;
    end
  endtask

  task automatic model_step();
    bit sl, sr, show, anyen, forced, bok, areq, acc, right;
    bit found, chgd, rnew;
    int tgt, cand;
    bit raw[2];
    sl = b_rise[0];
    sr = b_rise[1];
    show = (m_blank_left == 0);
    anyen = (chan_en != 0);
    forced = show && !lock && anyen && !chan_en[m_mode];
    bok = show && !lock && (sl != sr);
    areq = show && auto_en && !lock && (m_idle == AU - 1);
    acc = forced || bok || areq;
    right = forced || !bok || sr;
    tgt = m_mode;
    found = 0;
    for (int k = 1; k < N; k++) begin
      cand = right ? (m_mode + k) % N : (m_mode + N - k) % N;
      if (!found && chan_en[cand]) begin
        tgt = cand;
        found = 1;
      end
    end
    chgd = acc && (tgt != m_mode);
    m_chg = m_upd;
    m_upd = chgd;
    if (!auto_en || lock || acc) m_idle = 0;
    else if (show) m_idle++;
    if (chgd) m_mode = tgt;
    if (chgd && BL > 0) m_blank_left = BL;
    else if (m_blank_left > 0) m_blank_left--;
    if (m_blank_left == 0 && anyen) begin
      m_seg = chan_seg[m_mode*8 +: 8];
      m_dig = chan_dig[m_mode*8 +: 8];
    end else begin
      m_seg = 0;
      m_dig = 0;
    end
    raw[0] = btn_left;
    raw[1] = btn_right;
    for (int b = 0; b < 2; b++) begin
      rnew = 0;
      if (b_s2[b] != b_lvl[b]) begin
        b_run[b]++;
        if (b_run[b] == DB) begin
          rnew = b_s2[b] && b_arm[b];
          b_lvl[b] = b_s2[b];
          b_run[b] = 0;
        end
      end else begin
        b_run[b] = 0;
      end
      if (!b_s2[b]) b_arm[b] = 1;
      b_rise[b] = rnew;
      b_s2[b] = b_s1[b];
      b_s1[b] = raw[b];
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("mode", 32'(mode), 32'(m_mode));
      chk("seg", 32'(seg), 32'(m_seg));
      chk("dig", 32'(dig), 32'(m_dig));
      chk("mode_chg", 32'(mode_chg), 32'(m_chg));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      if (mode_chg) chg_seen++;
      chan_seg = {$urandom, $urandom};
      chan_dig = {$urandom, $urandom};
    end
  endtask

  task automatic press(input bit l, input bit r, input int n);
    btn_left = l;
    btn_right = r;
    tick(n);
    btn_left = 0;
    btn_right = 0;
    tick(12);
  endtask

  initial begin
    tick(3);
    chk("reset mode", 32'(mode), 0);
    chk("reset seg", 32'(seg), 0);
    chk("reset dig", 32'(dig), 0);
    chk("reset chg", 32'(mode_chg), 0);
    rst_n = 1;
    tick(10);

    press(1, 0, 6);
    chk("left 0->7", 32'(mode), 7);
    chg_seen = 0;
    press(0, 1, 6);
    chk("right 7->0", 32'(mode), 0);
    chk("one chg pulse", 32'(chg_seen), 1);

    chan_en = 8'b0010_0101;
    tick(4);
    press(1, 0, 6);
    chk("sparse left 0->5", 32'(mode), 5);
    press(1, 0, 6);
    chk("sparse left 5->2", 32'(mode), 2);

    chan_en = 8'hFF;
    press(0, 1, 3);
    chk("glitch ignored", 32'(mode), 2);
    press(1, 1, 6);
    chk("both ignored", 32'(mode), 2);

    auto_en = 1;
    tick(60);
    chk("auto three steps", 32'(mode), 5);
    lock = 1;
    tick(40);
    chk("locked", 32'(mode), 5);
    lock = 0;
    tick(15);
    chk("auto before 16", 32'(mode), 5);
    tick(1);
    chk("auto at 16", 32'(mode), 6);
    auto_en = 0;

    chan_en = 8'b0000_1000;
    tick(8);
    chk("skip to 3", 32'(mode), 3);
    chan_en = 8'hFF;
    tick(6);
    chan_en = 8'hF7;
    tick(1);
    chk("drop 3 -> 4", 32'(mode), 4);
    chan_en = 8'h00;
    tick(5);
    chk("none seg", 32'(seg), 0);
    chk("none dig", 32'(dig), 0);
    chk("none mode", 32'(mode), 4);

    chan_en = 8'hFF;
    tick(4);
    btn_right = 1;
    tick(7);
    chk("pre-reset step", 32'(mode), 5);
    #2 rst_n = 0;
    #1;
    chk("async mode", 32'(mode), 0);
    chk("async seg", 32'(seg), 0);
    chk("async dig", 32'(dig), 0);
    tick(2);
    rst_n = 1;
    tick(20);
    chk("held thru reset", 32'(mode), 0);
    btn_right = 0;
    tick(10);
    press(0, 1, 6);
    chk("repress", 32'(mode), 1);

    for (int i = 0; i < 3000; i++) begin
      tick(1);
      if ($urandom_range(0, 99) < 3)
        chan_en = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
      if (!lock && $urandom_range(0, 299) == 0) lock = 1;
      else if (lock && $urandom_range(0, 59) == 0) lock = 0;
      if ($urandom_range(0, 99) == 0) auto_en = !auto_en;
      if ($urandom_range(0, 7) == 0) btn_left = !btn_left;
      if ($urandom_range(0, 7) == 0) btn_right = !btn_right;
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule

// File: doc/display_mode_mux.md
DISPLAY_MODE_MUX -- requirements
Module: display_mode_mux

Interface
REQ-001 Parameter NUM_MODES, 8, number of display channels; legal range 2..16.
REQ-002 Parameter SEG_W, 8, segment bus width per channel.
REQ-003 Parameter DIG_W, 8, digit-select bus width per channel.
REQ-004 Parameter DEB_CYCLES, 1000000, stable cycles a button must hold before it is accepted.
REQ-005 Parameter BLANK_CYCLES, 4, blanking cycles inserted on every mode change; 0 disables blanking.
REQ-006 Parameter AUTO_CYCLES, 100000000, idle cycles before auto-advance.
REQ-007 Port clk, input, 1, sole clock; all state on rising edge.
REQ-008 Port rst_n, input, 1, reset, asynchronous, active-low.
REQ-009 Port btn_left / btn_right, input, 1 each, raw asynchronous buttons: previous / next mode.
REQ-010 Port lock, input, 1, high freezes the current mode.
REQ-011 Port auto_en, input, 1, enables idle auto-advance.
REQ-012 Port chan_en, input, NUM_MODES, per-channel enable; disabled channels are skipped.
REQ-013 Port chan_seg, input, NUM_MODES*SEG_W, channel i segments at bits [i*SEG_W +: SEG_W].
REQ-014 Port chan_dig, input, NUM_MODES*DIG_W, channel i digit selects at bits [i*DIG_W +: DIG_W].
REQ-015 Port mode, output, MODE_W = clog2(NUM_MODES), current mode index.
REQ-016 Port seg / dig, output, SEG_W / DIG_W, registered display drive.
REQ-017 Port mode_chg, output, 1, one-cycle pulse in the cycle after mode updates.

Function
REQ-018 Each button SHALL pass a 2-flop synchroniser, then a debouncer accepting a new level only after DEB_CYCLES consecutive equal samples.
REQ-019 A rising edge of a debounced level SHALL produce a one-cycle step request.
REQ-020 Right step SHALL select the next index above mode with chan_en set, wrapping NUM_MODES-1 to 0; left step the next below, wrapping 0 to NUM_MODES-1.
REQ-021 Left and right requests in the same cycle SHALL both be discarded.
REQ-022 If no other channel is enabled, a step SHALL leave mode unchanged and SHALL NOT pulse mode_chg.
REQ-023 While lock is high, step and auto requests SHALL be discarded, not queued.
REQ-024 Idle counter SHALL clear on any accepted step, on lock high, or on auto_en low; reaching AUTO_CYCLES-1 SHALL issue a right step and clear.
REQ-025 If chan_en[mode] is low and lock is low, the block SHALL perform a right step on the next cycle; if chan_en is all zero, mode holds and seg/dig are driven 0.
REQ-026 FSM states SHOW and BLANK: SHOW -> BLANK on mode change when BLANK_CYCLES>0; BLANK -> SHOW after exactly BLANK_CYCLES cycles.
REQ-027 In BLANK, seg and dig SHALL be 0; step requests arriving in BLANK SHALL be discarded.
REQ-028 In SHOW, seg/dig SHALL equal the selected channel slices with one clock of latency.
REQ-029 mode SHALL update one cycle after the accepted request; mode_chg pulses the following cycle.

Reset
REQ-030 rst_n low SHALL asynchronously force mode=0, seg=0, dig=0, mode_chg=0, FSM=SHOW, idle and blank counters=0, debounced levels=0.
REQ-031 A button held through reset deassertion SHALL NOT produce a step until released and pressed again.
REQ-032 After reset, mode 0 SHALL be shown even if chan_en[0] is 0, then REQ-025 applies.

Structure
REQ-033 Package display_pkg SHALL hold the FSM state type, MODE_W width function, and default timing constants.
REQ-034 Synchroniser plus debouncer SHALL be one sub-module, btn_debounce, instantiated twice.

Verification (NUM_MODES=8, DEB_CYCLES=4, BLANK_CYCLES=2, AUTO_CYCLES=16)
REQ-035 chan_en=8'hFF, mode=7, btn_right held 6 cycles -> mode=0, mode_chg one pulse, seg=dig=0 for 2 cycles, then channel 0 data.
REQ-036 chan_en=8'b0010_0101, mode=0, btn_left press -> mode=5; second press -> mode=2.
REQ-037 btn_right glitch high 3 cycles -> no mode change; both buttons pressed together -> no mode change.
REQ-038 auto_en=1, no presses, chan_en=8'hFF -> mode increments every 16 cycles plus blanking; lock=1 -> mode frozen, counter held at 0.
REQ-039 mode=3 displayed, chan_en[3] dropped -> mode=4 on next cycle; chan_en=0 -> seg=dig=0, mode holds.
REQ-040 rst_n asserted mid-BLANK with btn_right held -> outputs 0 immediately, mode=0, no step until release and repress.
